// File: rtl/haz_pkg.sv
// Shared definitions for the ID-stage hazard controller: RV64I major opcodes,
// controller state encodings and the per-instruction source/destination use record.
package haz_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } ctrl_state_e;

   typedef struct packed {
      logic use_rs1;
      logic use_rs2;
      logic writes_rd;
      logic is_load;
   } src_use_t;

endpackage

// File: rtl/hz_src_decode.sv
// Opcode classifier: which register sources an instruction reads, whether it
// writes rd, and whether it is a load. Unknown opcodes read and write nothing.
module hz_src_decode
   import haz_pkg::*;
(
   input  logic [6:0] opcode_i,
   output src_use_t   use_o
);

   // Pure opcode lookup; the rd != x0 qualification is applied by the caller.
   always_comb begin
      use_o = '0;
      case (opcode_i)
         OP_R:                  use_o = '{use_rs1: 1'b1, use_rs2: 1'b1, writes_rd: 1'b1, is_load: 1'b0};
         OP_STORE, OP_BRANCH:   use_o = '{use_rs1: 1'b1, use_rs2: 1'b1, writes_rd: 1'b0, is_load: 1'b0};
         OP_IMM, OP_JALR:       use_o = '{use_rs1: 1'b1, use_rs2: 1'b0, writes_rd: 1'b1, is_load: 1'b0};
         OP_LOAD:               use_o = '{use_rs1: 1'b1, use_rs2: 1'b0, writes_rd: 1'b1, is_load: 1'b1};
         OP_LUI, OP_AUIPC,
         OP_JAL:                use_o = '{use_rs1: 1'b0, use_rs2: 1'b0, writes_rd: 1'b1, is_load: 1'b0};
         default:               use_o = '0;
      endcase
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order issue controller between IF/ID and EX. A per-register countdown
// scoreboard detects RAW hazards, EX redirects squash IF/ID, and ex_ready=0
// freezes the controller. Optional macro HAZ_FWD_EN: EX/MEM forwarding present,
// so ALU-class writers never stall dependents and loads stall for LOAD_LAT.
module pipe_hazard_ctrl
   import haz_pkg::*;
#(
   parameter int RAW_LAT   = 2,
   parameter int LOAD_LAT  = 1,
   parameter int FLUSH_CYC = 1,
   parameter int CNT_W     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_inst,
   input  logic        ex_redirect,
   input  logic        ex_ready,
   output logic        id_issue,
   output logic        stall_if,
   output logic        stall_id,
   output logic        flush_if_id,
   output logic [1:0]  ctrl_state,
   output logic [31:0] stall_cycles
);

   localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYC - 1);
   localparam logic [CNT_W-1:0] RAW_SET    = CNT_W'(RAW_LAT);
   localparam logic [CNT_W-1:0] LOAD_SET   = CNT_W'(LOAD_LAT);

   src_use_t          use_s;
   logic [4:0]        rs1, rs2, rd;
   logic [31:0]       busy_vec;
   logic              hazard, issue, stall, sb_set;
   logic [CNT_W-1:0]  set_val;
   ctrl_state_e       state_q, state_d;
   logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic [31:0]       stall_cnt_q;
   logic              unused_bits;

   assign rs1 = id_inst[19:15];
   assign rs2 = id_inst[24:20];
   assign rd  = id_inst[11:7];

   hz_src_decode u_dec (
      .opcode_i (id_inst[6:0]),
      .use_o    (use_s)
   );

   // A squashed or stalled instruction never reaches this point, so only real issues reserve rd.
   assign sb_set = issue & use_s.writes_rd & (rd != 5'd0);

`ifdef HAZ_FWD_EN
   assign set_val = use_s.is_load ? LOAD_SET : '0;
`else
   assign set_val = RAW_SET;
`endif

   assign unused_bits = ^{id_inst[31:25], id_inst[14:12], use_s.is_load, LOAD_SET};

   // One countdown per architectural register; x0 is hard-wired idle.
   for (genvar gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
         assign busy_vec[gi] = 1'b0;
      end else begin : g_xn
         logic [CNT_W-1:0] cnt_q, cnt_d;

         // Age the entry each live cycle; a new issue to this rd overrides it (WAW).
         always_comb begin
            cnt_d = cnt_q;
            if (ex_ready) begin
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
               if (sb_set && rd == 5'(gi)) cnt_d = set_val;
            end
         end

         // Counter register.
         always_ff @(posedge clk) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
         end

         assign busy_vec[gi] = (cnt_q != '0);
      end
   end

   // Hazard, issue/stall/flush outputs and FSM next state; all outputs read 0 while in reset.
   always_comb begin
      hazard       = id_valid & ((use_s.use_rs1 & busy_vec[rs1]) | (use_s.use_rs2 & busy_vec[rs2]));
      issue        = ~rst & id_valid & ex_ready & ~hazard & (state_q != ST_FLUSH) & ~ex_redirect;
      stall        = ~rst & (hazard | ~ex_ready) & (state_q != ST_FLUSH) & ~ex_redirect;
      id_issue     = issue;
      stall_if     = stall;
      stall_id     = stall;
      flush_if_id  = ~rst & (ex_redirect | (state_q == ST_FLUSH));
      ctrl_state   = rst ? 2'd0 : state_q;
      stall_cycles = rst ? 32'd0 : stall_cnt_q;
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      if (ex_ready) begin
         if (ex_redirect) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
         end else begin
            case (state_q)
               ST_RUN:   if (hazard)  state_d = ST_STALL;
               ST_STALL: if (!hazard) state_d = ST_RUN;
               ST_FLUSH: begin
                  if (flush_cnt_q == '0) state_d = ST_RUN;
                  else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
               end
               default:  state_d = ST_RUN;
            endcase
         end
      end
   end

   // FSM and flush-length registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Saturating count of stalled cycles, frozen cycles included.
   always_ff @(posedge clk) begin
      if (rst)                                 stall_cnt_q <= '0;
      else if (stall && stall_cnt_q != '1)     stall_cnt_q <= stall_cnt_q + 32'd1;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. The reference model tracks, per
// register, the live-cycle number at which its value becomes readable, and
// derives the controller outputs from the stated issue/stall/flush rules.
module tb_pipe_hazard_ctrl;
   import haz_pkg::*;

   localparam int RAW_LAT   = 2;
   localparam int LOAD_LAT  = 1;
   localparam int FLUSH_CYC = 1;
`ifdef HAZ_FWD_EN
   localparam int ALU_W = 0;
   localparam int LD_W  = LOAD_LAT;
`else
   localparam int ALU_W = RAW_LAT;
   localparam int LD_W  = RAW_LAT;
`endif

   logic        clk = 1'b0;
   logic        rst, id_valid, ex_redirect, ex_ready;
   logic [31:0] id_inst;
   logic        id_issue, stall_if, stall_id, flush_if_id;
   logic [1:0]  ctrl_state;
   logic [31:0] stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        r;
      logic        v;
      logic [31:0] inst;
      logic        redir;
      logic        rdy;
   } stim_t;

   // reference model state
   longint unsigned act;
   longint unsigned ready_at [32];
   int              mst;
   int              flush_left;
   logic [31:0]     mstall;
   logic            e_haz, e_issue, e_stall, e_flush;
   logic [5:0]      exp_vec;
   logic [31:0]     exp_cyc;
   logic            e_u1, e_u2, e_wr;
   int              e_lat;

   pipe_hazard_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_inst      (id_inst),
      .ex_redirect  (ex_redirect),
      .ex_ready     (ex_ready),
      .id_issue     (id_issue),
      .stall_if     (stall_if),
      .stall_id     (stall_id),
      .flush_if_id  (flush_if_id),
      .ctrl_state   (ctrl_state),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
      return {7'b0, s2, s1, 3'b000, rd, OP_R};
   endfunction

   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] s1);
      return {12'd4, s1, 3'b000, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] imm);
      return {7'b0, s2, s1, 3'b010, imm, OP_STORE};
   endfunction

   function automatic stim_t mk(input logic r, input logic v, input logic [31:0] inst,
                                input logic redir, input logic rdy);
      stim_t s;
      s.r = r; s.v = v; s.inst = inst; s.redir = redir; s.rdy = rdy;
      return s;
   endfunction

   task automatic classify(input logic [31:0] inst);
      e_u1 = 1'b0; e_u2 = 1'b0; e_wr = 1'b0; e_lat = 0;
      case (inst[6:0])
         OP_R:                 begin e_u1 = 1; e_u2 = 1; e_wr = 1; e_lat = ALU_W; end
         OP_STORE, OP_BRANCH:  begin e_u1 = 1; e_u2 = 1; end
         OP_IMM, OP_JALR:      begin e_u1 = 1; e_wr = 1; e_lat = ALU_W; end
         OP_LOAD:              begin e_u1 = 1; e_wr = 1; e_lat = LD_W; end
         OP_LUI, OP_AUIPC,
         OP_JAL:               begin e_wr = 1; e_lat = ALU_W; end
         default:              ;
      endcase
   endtask

   function automatic logic busy(input logic [4:0] r);
      return (r != 5'd0) && (act < ready_at[r]);
   endfunction

   task automatic model_clear();
      act = 0; mst = 0; flush_left = 0; mstall = 0;
      for (int i = 0; i < 32; i++) ready_at[i] = 0;
   endtask

   task automatic eval_model();
      classify(id_inst);
      e_haz   = id_valid & ((e_u1 & busy(id_inst[19:15])) | (e_u2 & busy(id_inst[24:20])));
      e_issue = 1'b0; e_stall = 1'b0; e_flush = 1'b0;
      if (!rst) begin
         e_issue = id_valid & ex_ready & ~e_haz & (mst != 2) & ~ex_redirect;
         e_stall = (e_haz | ~ex_ready) & (mst != 2) & ~ex_redirect;
         e_flush = ex_redirect | (mst == 2);
      end
      exp_vec = {e_issue, e_stall, e_stall, e_flush, (rst ? 2'd0 : 2'(mst))};
      exp_cyc = rst ? 32'd0 : mstall;
   endtask

   task automatic commit_model();
      if (rst) begin
         model_clear();
      end else begin
         if (e_stall && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
         if (ex_ready) begin
            if (e_issue && e_wr && id_inst[11:7] != 5'd0)
               ready_at[id_inst[11:7]] = act + longint'(e_lat) + 1;
            act = act + 1;
            if (ex_redirect) begin
               mst = 2; flush_left = FLUSH_CYC;
            end else if (mst == 0) begin
               if (e_haz) mst = 1;
            end else if (mst == 1) begin
               if (!e_haz) mst = 0;
            end else begin
               flush_left = flush_left - 1;
               if (flush_left <= 0) mst = 0;
            end
         end
      end
   endtask

   task automatic drive(input stim_t s);
      rst = s.r; id_valid = s.v; id_inst = s.inst; ex_redirect = s.redir; ex_ready = s.rdy;
      @(negedge clk);
      eval_model();
   endtask

   task automatic advance(input string name, input int i);
      $display("[TB] %s c%0d rst=%b v=%b inst=%h redir=%b rdy=%b -> issue=%b stall=%b flush=%b st=%0d cyc=%0d",
               name, i, rst, id_valid, id_inst, ex_redirect, ex_ready, id_issue, stall_id,
               flush_if_id, ctrl_state, stall_cycles);
      @(posedge clk);
      commit_model();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(mk(0, 0, 32'h0, 0, 1));
         advance("idle", i);
      end
   endtask

   task automatic test_reset();
      stim_t q[$];
      q.push_back(mk(1, 1, enc_r(5'd5, 5'd1, 5'd2), 1, 1));
      q.push_back(mk(1, 1, enc_r(5'd6, 5'd5, 5'd3), 0, 0));
      q.push_back(mk(0, 1, enc_r(5'd5, 5'd1, 5'd2), 0, 1));   // producer of x5
      q.push_back(mk(1, 0, 32'h0, 0, 1));                    // reset right after
      q.push_back(mk(0, 1, enc_r(5'd7, 5'd5, 5'd5), 0, 1));   // reader must not stall
      foreach (q[i]) begin
         drive(q[i]);
         n_tests++;
         if ({id_issue, stall_if, stall_id, flush_if_id, ctrl_state} !== exp_vec) begin
            n_fail++;
            $display("FAIL reset c%0d outs=%b expected=%b", i,
                     {id_issue, stall_if, stall_id, flush_if_id, ctrl_state}, exp_vec);
         end
         n_tests++;
         if (stall_cycles !== exp_cyc) begin
            n_fail++;
            $display("FAIL reset_cyc c%0d got=%0d expected=%0d", i, stall_cycles, exp_cyc);
         end
         if (q[i].r) begin
            n_tests++;
            if ({id_issue, stall_if, stall_id, flush_if_id, ctrl_state, stall_cycles} !== 38'd0) begin
               n_fail++;
               $display("FAIL reset_zero c%0d outs=%b cyc=%0d expected all zero", i,
                        {id_issue, stall_if, stall_id, flush_if_id, ctrl_state}, stall_cycles);
            end
         end
         if (i == 4) begin
            n_tests++;
            if (id_issue !== 1'b1) begin
               n_fail++;
               $display("FAIL reset_clears_sb got issue=%b expected 1", id_issue);
            end
         end
         advance("reset", i);
      end
   endtask

   // Dependent add held in ID until it issues; also covers the ALU->ALU case of the forwarding build.
   task automatic test_raw_basic();
      stim_t q[$];
      logic [31:0] base;
      idle(3);
      base = mstall;
      q.push_back(mk(0, 1, enc_r(5'd5, 5'd1, 5'd2), 0, 1));
      for (int k = 0; k < 3; k++) q.push_back(mk(0, 1, enc_r(5'd6, 5'd5, 5'd3), 0, 1));
      q.push_back(mk(0, 0, 32'h0, 0, 1));
      foreach (q[i]) begin
         drive(q[i]);
         n_tests++;
         if ({id_issue, stall_if, stall_id, flush_if_id, ctrl_state} !== exp_vec) begin
            n_fail++;
            $display("FAIL raw_basic c%0d outs=%b expected=%b", i,
                     {id_issue, stall_if, stall_id, flush_if_id, ctrl_state}, exp_vec);
         end
`ifndef HAZ_FWD_EN
         if (i == 3) begin
            n_tests++;
            if (id_issue !== 1'b1) begin
               n_fail++;
               $display("FAIL raw_issue_t3 got=%b expected=1", id_issue);
            end
         end
`endif
         advance("raw_basic", i);
      end
      n_tests++;
      if (stall_cycles !== base + 32'(ALU_W)) begin
         n_fail++;
         $display("FAIL raw_stall_count got=%0d expected=%0d", stall_cycles, base + 32'(ALU_W));
      end
   endtask

   task automatic test_load_use();
      stim_t q[$];
      logic [31:0] base;
      idle(3);
      base = mstall;
      q.push_back(mk(0, 1, enc_i(OP_LOAD, 5'd5, 5'd1), 0, 1));
      for (int k = 0; k < 3; k++) q.push_back(mk(0, 1, enc_r(5'd6, 5'd5, 5'd5), 0, 1));
      q.push_back(mk(0, 0, 32'h0, 0, 1));
      foreach (q[i]) begin
         drive(q[i]);
         n_tests++;
         if ({id_issue, stall_if, stall_id, flush_if_id, ctrl_state} !== exp_vec) begin
            n_fail++;
            $display("FAIL load_use c%0d outs=%b expected=%b", i,
                     {id_issue, stall_if, stall_id, flush_if_id, ctrl_state}, exp_vec);
         end
         advance("load_use", i);
      end
      n_tests++;
      if (stall_cycles !== base + 32'(LD_W)) begin
         n_fail++;
         $display("FAIL load_stall_count got=%0d expected=%0d", stall_cycles, base + 32'(LD_W));
      end
   endtask

   task automatic test_x0_store();
      stim_t q[$];
      logic [31:0] base;
      idle(3);
      base = mstall;
      q.push_back(mk(0, 1, enc_i(OP_IMM, 5'd0, 5'd1), 0, 1));   // addi x0,x1,4
      q.push_back(mk(0, 1, enc_r(5'd7, 5'd0, 5'd0), 0, 1));      // add x7,x0,x0
      q.push_back(mk(0, 1, enc_s(5'd1, 5'd2, 5'd5), 0, 1));      // sw with rd field = 5
      q.push_back(mk(0, 1, enc_r(5'd8, 5'd5, 5'd5), 0, 1));      // reader of x5
      foreach (q[i]) begin
         drive(q[i]);
         n_tests++;
         if (id_issue !== 1'b1 || stall_id !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_store c%0d issue=%b stall=%b expected issue=1 stall=0", i, id_issue, stall_id);
         end
         advance("x0_store", i);
      end
      n_tests++;
      if (stall_cycles !== base) begin
         n_fail++;
         $display("FAIL x0_store_count got=%0d expected=%0d", stall_cycles, base);
      end
   endtask

   task automatic test_redirect_stall();
      stim_t q[$];
      idle(3);
      q.push_back(mk(0, 1, enc_r(5'd5, 5'd1, 5'd2), 0, 1));
      q.push_back(mk(0, 1, enc_r(5'd6, 5'd5, 5'd3), 0, 1));
      q.push_back(mk(0, 1, enc_r(5'd6, 5'd5, 5'd3), 1, 1));
      q.push_back(mk(0, 1, enc_r(5'd6, 5'd5, 5'd3), 0, 1));
      q.push_back(mk(0, 1, enc_r(5'd6, 5'd5, 5'd3), 0, 1));
      foreach (q[i]) begin
         drive(q[i]);
         n_tests++;
         if ({id_issue, stall_if, stall_id, flush_if_id, ctrl_state} !== exp_vec) begin
            n_fail++;
            $display("FAIL redirect c%0d outs=%b expected=%b", i,
                     {id_issue, stall_if, stall_id, flush_if_id, ctrl_state}, exp_vec);
         end
         if (i == 2) begin
            n_tests++;
            if (flush_if_id !== 1'b1 || stall_id !== 1'b0 || id_issue !== 1'b0) begin
               n_fail++;
               $display("FAIL redirect_same_cycle flush=%b stall=%b issue=%b expected 1/0/0",
                        flush_if_id, stall_id, id_issue);
            end
         end
         if (i == 3) begin
            n_tests++;
            if (ctrl_state !== 2'd2 || id_issue !== 1'b0) begin
               n_fail++;
               $display("FAIL redirect_flush_state st=%0d issue=%b expected st=2 issue=0", ctrl_state, id_issue);
            end
         end
         if (i == 4) begin
            n_tests++;
            if (ctrl_state !== 2'd0) begin
               n_fail++;
               $display("FAIL redirect_back_run st=%0d expected 0", ctrl_state);
            end
         end
         advance("redirect", i);
      end
   endtask

   task automatic test_freeze();
      stim_t q[$];
      logic [31:0] base;
      idle(3);
      base = mstall;
      q.push_back(mk(0, 1, enc_r(5'd5, 5'd1, 5'd2), 0, 1));
      for (int k = 0; k < 3; k++) q.push_back(mk(0, 1, enc_r(5'd6, 5'd5, 5'd3), 0, 0));
      for (int k = 0; k < 3; k++) q.push_back(mk(0, 1, enc_r(5'd6, 5'd5, 5'd3), 0, 1));
      q.push_back(mk(0, 0, 32'h0, 0, 1));
      foreach (q[i]) begin
         drive(q[i]);
         n_tests++;
         if ({id_issue, stall_if, stall_id, flush_if_id, ctrl_state} !== exp_vec) begin
            n_fail++;
            $display("FAIL freeze c%0d outs=%b expected=%b", i,
                     {id_issue, stall_if, stall_id, flush_if_id, ctrl_state}, exp_vec);
         end
         n_tests++;
         if (stall_cycles !== exp_cyc) begin
            n_fail++;
            $display("FAIL freeze_cyc c%0d got=%0d expected=%0d", i, stall_cycles, exp_cyc);
         end
         advance("freeze", i);
      end
      n_tests++;
      if (stall_cycles !== base + 32'(3 + ALU_W)) begin
         n_fail++;
         $display("FAIL freeze_count got=%0d expected=%0d", stall_cycles, base + 32'(3 + ALU_W));
      end
   endtask

   task automatic test_reset_in_flush();
      stim_t q[$];
      idle(3);
      q.push_back(mk(0, 1, enc_r(5'd5, 5'd1, 5'd2), 0, 1));
      q.push_back(mk(0, 0, 32'h0, 1, 1));
      q.push_back(mk(1, 0, 32'h0, 0, 1));
      q.push_back(mk(0, 0, 32'h0, 0, 1));
      q.push_back(mk(0, 1, enc_r(5'd6, 5'd5, 5'd5), 0, 1));
      foreach (q[i]) begin
         drive(q[i]);
         n_tests++;
         if ({id_issue, stall_if, stall_id, flush_if_id, ctrl_state} !== exp_vec) begin
            n_fail++;
            $display("FAIL rst_flush c%0d outs=%b expected=%b", i,
                     {id_issue, stall_if, stall_id, flush_if_id, ctrl_state}, exp_vec);
         end
         if (i == 3) begin
            n_tests++;
            if ({id_issue, stall_if, stall_id, flush_if_id, ctrl_state, stall_cycles} !== 38'd0) begin
               n_fail++;
               $display("FAIL rst_flush_zero outs=%b cyc=%0d expected all zero",
                        {id_issue, stall_if, stall_id, flush_if_id, ctrl_state}, stall_cycles);
            end
         end
         if (i == 4) begin
            n_tests++;
            if (id_issue !== 1'b1) begin
               n_fail++;
               $display("FAIL rst_flush_reader issue=%b expected 1", id_issue);
            end
         end
         advance("rst_flush", i);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [10];
      stim_t s;
      ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b1111111};
      for (int i = 0; i < 400; i++) begin
         s.r     = ($urandom_range(0, 149) == 0);
         s.v     = ($urandom_range(0, 99) < 80);
         s.inst  = {7'b0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'b000,
                    5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]};
         s.rdy   = ($urandom_range(0, 99) < 85);
         s.redir = s.rdy && ($urandom_range(0, 99) < 10);
         drive(s);
         n_tests++;
         if ({id_issue, stall_if, stall_id, flush_if_id, ctrl_state} !== exp_vec) begin
            n_fail++;
            $display("FAIL random c%0d outs=%b expected=%b", i,
                     {id_issue, stall_if, stall_id, flush_if_id, ctrl_state}, exp_vec);
         end
         n_tests++;
         if (stall_cycles !== exp_cyc) begin
            n_fail++;
            $display("FAIL random_cyc c%0d got=%0d expected=%0d", i, stall_cycles, exp_cyc);
         end
         advance("random", i);
      end
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_inst = 32'h0; ex_redirect = 1'b0; ex_ready = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      test_reset();
      test_raw_basic();
      test_load_use();
      test_x0_store();
      test_redirect_stall();
      test_freeze();
      test_reset_in_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
